multicycle_ctrl: RTL and testbench

//  Multicycle control FSM for the MIPS-subset datapath. Sequences FETCH/DECODE/EXEC/MEM/WB
//  and drives datapath selects, including ext_sel for the immediate extender (sign vs zero).

---
 rtl/multicycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for a MIPS-subset datapath: FETCH/DECODE/EXEC/MEM/WB sequencing
// with a variable-latency memory handshake. Optional perf counters: define MC_PERF_CNT_EN.
module multicycle_ctrl #(
  parameter int OPW  = 6,
  parameter int CNTW = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] funct,
  input  logic           mem_ready,
  input  logic           zero,
  output logic           pc_write,
  output logic [1:0]     pc_src,
  output logic           ir_write,
  output logic           mem_read,
  output logic           mem_write,
  output logic           iord,
  output logic           alu_src,
  output logic           ext_sel,
  output logic [2:0]     alu_op,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           reg_write,
  output logic           halted,
  output logic           illegal
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNTW-1:0] cyc_cnt,
  output logic [CNTW-1:0] instr_cnt
`endif
);

  // state  | meaning
  // IDLE   | waiting for start, all outputs low
  // FETCH  | instruction read at PC, held until mem_ready
  // DECODE | opcode/funct latched, illegal opcodes trap to HALT
  // EXEC   | ALU operation, branch/jump resolution
  // MEM    | data read (lw) or write (sw), held until mem_ready
  // WB     | register file write
  // HALT   | absorbing until reset
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(6'b111111);

  state_t         state;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] funct_q;

  function automatic logic is_legal(input logic [OPW-1:0] op);
    case (op)
      OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  // funct is consumed by the downstream ALU control; the latched copy is kept for debug probing
  logic funct_q_unused;
  assign funct_q_unused = ^funct_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= '0;
      funct_q <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE:   if (start) state <= FETCH;
        FETCH:  if (mem_ready) state <= DECODE;
        DECODE: begin
          op_q    <= opcode;
          funct_q <= funct;
          if (is_legal(opcode)) begin
            state <= EXEC;
          end else begin
            state   <= HALT;
            illegal <= 1'b1;
          end
        end
        EXEC: begin
          case (op_q)
            OP_R, OP_ADDI, OP_ANDI, OP_ORI: state <= WB;
            OP_LW, OP_SW:                   state <= MEM;
            OP_BEQ, OP_J:                   state <= FETCH;
            default:                        state <= HALT;
          endcase
        end
        MEM:    if (mem_ready) state <= (op_q == OP_LW) ? WB : FETCH;
        WB:     state <= FETCH;
        HALT:   state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    alu_src    = 1'b0;
    ext_sel    = 1'b0;
    alu_op     = 3'd0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    halted     = (state == HALT);
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      EXEC: begin
        case (op_q)
          OP_R:    begin alu_op = 3'd4; reg_dst = 1'b1; end
          OP_ADDI: begin alu_src = 1'b1; alu_op = 3'd0; end
          OP_ANDI: begin alu_src = 1'b1; alu_op = 3'd2; end
          OP_ORI:  begin alu_src = 1'b1; alu_op = 3'd3; end
          OP_LW, OP_SW: begin alu_src = 1'b1; alu_op = 3'd0; end
          OP_BEQ:  begin alu_op = 3'd1; pc_write = zero; pc_src = 2'd1; end
          OP_J:    begin pc_write = 1'b1; pc_src = 2'd2; end
          default: ;
        endcase
      end
      MEM: begin
        iord      = 1'b1;
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LW);
        reg_dst    = (op_q == OP_R);
      end
      default: ;
    endcase
    // sign extension only matters for ops that use the immediate arithmetically
    if (state == EXEC || state == MEM || state == WB)
      ext_sel = (op_q == OP_ADDI) || (op_q == OP_LW) || (op_q == OP_SW) || (op_q == OP_BEQ);
  end

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != IDLE && state != HALT) cyc_cnt <= cyc_cnt + CNTW'(1);
      if (state == DECODE && is_legal(opcode)) instr_cnt <= instr_cnt + CNTW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle counts and output
// occupancy compared against a CPI/occupancy model derived from the instruction rules.
module tb_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       reset, start, mem_ready, zero;
  logic [5:0] opcode, funct;
  logic       pc_write, ir_write, mem_read, mem_write, iord, alu_src, ext_sel;
  logic       reg_dst, mem_to_reg, reg_write, halted, illegal;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
                         OP_ORI = 6'b001101, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_HALT = 6'b111111;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .zero(zero), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .alu_src(alu_src), .ext_sel(ext_sel), .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .halted(halted), .illegal(illegal)
`ifdef MC_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [16:0] outs;
  assign outs = {pc_write, pc_src, ir_write, mem_read, mem_write, iord, alu_src, ext_sel,
                 alu_op, reg_dst, mem_to_reg, reg_write, halted, illegal};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // CPI rule: R/I=4, lw=5, sw=4, beq/j=3, plus wait cycles per memory access
  function automatic int exp_cycles(input logic [5:0] op, input int fw, input int mw);
    case (op)
      OP_LW:        return 5 + fw + mw;
      OP_SW:        return 4 + fw + mw;
      OP_BEQ, OP_J: return 3 + fw;
      default:      return 4 + fw;
    endcase
  endfunction

  task automatic apply_reset();
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (outs !== 17'd0) begin
      n_err++; $display("FAIL idle_outputs: got %h want 0", outs);
    end
    step();
    start = 1'b0;
  endtask

  // One instruction from its first FETCH cycle, fetch wait fw, data wait mw, zero flag z
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
    int e;
    int c_ir, ir_k, c_pcw, c_mr, c_mw, c_iord, c_src, c_ext, c_rdst, c_m2r, c_rw, c_bad;
    logic [2:0] aop, exp_aop;
    logic [1:0] psrc;
    bit is_mem, is_lw, is_sw, is_imm, wr;
    is_lw  = (op == OP_LW);
    is_sw  = (op == OP_SW);
    is_mem = is_lw || is_sw;
    is_imm = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || is_mem;
    wr     = (op == OP_R) || (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || is_lw;
    e = exp_cycles(op, fw, mw);
    c_ir = 0; ir_k = -1; c_pcw = 0; c_mr = 0; c_mw = 0; c_iord = 0; c_src = 0;
    c_ext = 0; c_rdst = 0; c_m2r = 0; c_rw = 0; c_bad = 0; aop = '0; psrc = '0;
    opcode = op;
    funct  = 6'($urandom);
    for (int k = 0; k < e; k++) begin
      if (k == fw || (is_mem && k == fw + 3 + mw)) mem_ready = 1'b1;
      else if (k > fw && !(is_mem && k >= fw + 3)) mem_ready = 1'($urandom);
      else mem_ready = 1'b0;
      zero = (op == OP_BEQ) ? z : 1'($urandom);
      @(negedge clk);
      if (k == 0) begin
        n_cmp++;
        if (!(mem_read === 1'b1 && iord === 1'b0)) begin
          n_err++; $display("FAIL fetch_start op=%b: mem_read=%b iord=%b want 1/0", op, mem_read, iord);
        end
      end
      if (ir_write) begin c_ir++; ir_k = k; end
      c_pcw  += int'(pc_write);
      c_mr   += int'(mem_read);
      c_mw   += int'(mem_write);
      c_iord += int'(iord);
      c_src  += int'(alu_src);
      c_ext  += int'(ext_sel);
      c_rdst += int'(reg_dst);
      c_m2r  += int'(mem_to_reg);
      c_rw   += int'(reg_write);
      c_bad  += int'(halted | illegal);
      if (k == fw + 2) begin aop = alu_op; psrc = pc_src; end
      step();
    end
    case (op)
      OP_R:    exp_aop = 3'd4;
      OP_ANDI: exp_aop = 3'd2;
      OP_ORI:  exp_aop = 3'd3;
      OP_BEQ:  exp_aop = 3'd1;
      default: exp_aop = 3'd0;
    endcase
    n_cmp++;
    if (c_ir !== 1 || ir_k !== fw) begin
      n_err++; $display("FAIL ir_write op=%b: count=%0d at=%0d want 1 at %0d", op, c_ir, ir_k, fw);
    end
    n_cmp++;
    if (c_pcw !== 1 + int'(op == OP_J || (op == OP_BEQ && z))) begin
      n_err++; $display("FAIL pc_write op=%b z=%b: count=%0d", op, z, c_pcw);
    end
    n_cmp++;
    if (c_mr !== fw + 1 + (is_lw ? mw + 1 : 0)) begin
      n_err++; $display("FAIL mem_read op=%b: count=%0d want %0d", op, c_mr, fw + 1 + (is_lw ? mw + 1 : 0));
    end
    n_cmp++;
    if (c_mw !== (is_sw ? mw + 1 : 0) || c_iord !== (is_mem ? mw + 1 : 0)) begin
      n_err++; $display("FAIL mem_write_iord op=%b: write=%0d iord=%0d", op, c_mw, c_iord);
    end
    n_cmp++;
    if (c_src !== int'(is_imm) || aop !== exp_aop) begin
      n_err++; $display("FAIL exec_alu op=%b: alu_src=%0d alu_op=%0d want %0d/%0d", op, c_src, aop, is_imm, exp_aop);
    end
    n_cmp++;
    if (c_ext !== ((op == OP_ADDI) ? 2 : is_lw ? mw + 3 : is_sw ? mw + 2 : (op == OP_BEQ) ? 1 : 0)) begin
      n_err++; $display("FAIL ext_sel op=%b: count=%0d", op, c_ext);
    end
    n_cmp++;
    if (c_rw !== int'(wr) || c_m2r !== int'(is_lw) || c_rdst !== ((op == OP_R) ? 2 : 0)) begin
      n_err++; $display("FAIL writeback op=%b: reg_write=%0d mem_to_reg=%0d reg_dst=%0d", op, c_rw, c_m2r, c_rdst);
    end
    if (op == OP_J || (op == OP_BEQ && z)) begin
      n_cmp++;
      if (psrc !== ((op == OP_J) ? 2'd2 : 2'd1)) begin
        n_err++; $display("FAIL pc_src op=%b: got %0d", op, psrc);
      end
    end
    n_cmp++;
    if (c_bad !== 0) begin
      n_err++; $display("FAIL spurious_halt op=%b: cycles=%0d want 0", op, c_bad);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_cmp++;
    if (outs !== 17'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (outs !== 17'd0) begin
      n_err++; $display("FAIL idle_without_start: got %h want 0", outs);
    end
    step();
  endtask

  task automatic test_directed();
    apply_reset();
    do_start();
    run_instr(OP_ADDI, 0, 0, 1'b0);
    run_instr(OP_ORI, 3, 0, 1'b0);
    run_instr(OP_LW, 0, 2, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b1);
    run_instr(OP_BEQ, 1, 0, 1'b0);
    run_instr(OP_J, 0, 0, 1'b0);
    run_instr(OP_SW, 2, 1, 1'b0);
    run_instr(OP_R, 0, 0, 1'b0);
    run_instr(OP_ANDI, 1, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    ops = '{OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J};
    apply_reset();
    do_start();
    for (int i = 0; i < 40; i++)
      run_instr(ops[$urandom_range(7, 0)], int'($urandom_range(3, 0)),
                int'($urandom_range(3, 0)), 1'($urandom));
    mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!(mem_read === 1'b1 && iord === 1'b0 && ir_write === 1'b0)) begin
      n_err++; $display("FAIL final_fetch: mem_read=%b iord=%b ir_write=%b", mem_read, iord, ir_write);
    end
    step();
  endtask

  task automatic test_reset_mid_sw();
    apply_reset();
    do_start();
    opcode = OP_SW;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    n_cmp++;
    if (mem_write !== 1'b1 || iord !== 1'b1) begin
      n_err++; $display("FAIL sw_mem_phase: mem_write=%b iord=%b want 1/1", mem_write, iord);
    end
    reset = 1'b1;
    step();
    @(negedge clk);
    n_cmp++;
    if (outs !== 17'd0) begin
      n_err++; $display("FAIL reset_mid_sw: got %h want 0", outs);
    end
    reset = 1'b0;
    step();
    @(negedge clk);
    n_cmp++;
    if (outs !== 17'd0) begin
      n_err++; $display("FAIL idle_after_abort: got %h want 0", outs);
    end
    step();
  endtask

  task automatic test_illegal();
    apply_reset();
    do_start();
    opcode = 6'b010101;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom);
      mem_ready = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (halted !== 1'b1 || illegal !== 1'b1 ||
          {pc_write, ir_write, mem_read, mem_write, reg_write} !== 5'd0) begin
        n_err++; $display("FAIL illegal_halt: halted=%b illegal=%b outs=%h", halted, illegal, outs);
      end
      step();
    end
    start = 1'b0;
    reset = 1'b1;
    step();
    @(negedge clk);
    n_cmp++;
    if (halted !== 1'b0 || illegal !== 1'b0) begin
      n_err++; $display("FAIL reset_clears_halt: halted=%b illegal=%b want 0/0", halted, illegal);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_halt_op();
    apply_reset();
    do_start();
    opcode = OP_HALT;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    step();
    start = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (halted !== 1'b1 || illegal !== 1'b0 || mem_read !== 1'b0) begin
      n_err++; $display("FAIL halt_opcode: halted=%b illegal=%b mem_read=%b want 1/0/0", halted, illegal, mem_read);
    end
    step();
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_sw();
    test_illegal();
    test_halt_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
